// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and sizes for the decode hazard controller
package hazard_pkg;

  localparam int NUM_STAGES = 3;
  localparam int REG_W      = 3;
  localparam int NUM_REGS   = 1 << REG_W;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [REG_W-1:0] wr_num;
  } entry_t;

  function automatic logic writes_reg(input entry_t e, input logic [REG_W-1:0] r);
    return e.valid & e.wr_en & (e.wr_num == r);
  endfunction

endpackage

// File: rtl/inflight_tracker.sv
// rtl/inflight_tracker.sv - EX/MEM/WB shift register of in-flight writes with match and mask
module inflight_tracker
  import hazard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue,
  input  logic                wr_en,
  input  logic [REG_W-1:0]    wr_num,
  input  logic [REG_W-1:0]    r1_sel,
  input  logic [REG_W-1:0]    r2_sel,
  output logic                r1_match,
  output logic                r2_match,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                empty
);

  // index 0 = EX, 1 = MEM, 2 = WB; WB still counts since the regfile has no bypass
  entry_t stage_q [NUM_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= issue ? entry_t'{valid: 1'b1, wr_en: wr_en, wr_num: wr_num} : '0;
      for (int i = 1; i < NUM_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_comb begin
    r1_match     = 1'b0;
    r2_match     = 1'b0;
    pending_mask = '0;
    empty        = 1'b1;
    for (int i = 0; i < NUM_STAGES; i++) begin
      r1_match = r1_match | writes_reg(stage_q[i], r1_sel);
      r2_match = r2_match | writes_reg(stage_q[i], r2_sel);
      if (stage_q[i].valid & stage_q[i].wr_en) begin
        pending_mask[stage_q[i].wr_num] = 1'b1;
      end
      if (stage_q[i].valid) begin
        empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage RAW hazard stall, bubble and HALT drain control
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic                r1_used,
  input  logic                r2_used,
  input  logic [REG_W-1:0]    r1_sel,
  input  logic [REG_W-1:0]    r2_sel,
  input  logic                wr_en,
  input  logic [REG_W-1:0]    wr_num,
  input  logic                halt_in,
  input  logic                flush,
  output logic                stall,
  output logic                bubble,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                halted,
  output logic [15:0]         stall_cycles
);

  state_t      state_q;
  logic [15:0] stall_cnt_q;
  logic        r1_match;
  logic        r2_match;
  logic        tracker_empty;
  logic        run;
  logic        hazard;
  logic        issue;
  logic        hazard_stall;

  inflight_tracker u_tracker (
    .clk          (clk),
    .rst          (rst),
    .issue        (issue),
    .wr_en        (wr_en),
    .wr_num       (wr_num),
    .r1_sel       (r1_sel),
    .r2_sel       (r2_sel),
    .r1_match     (r1_match),
    .r2_match     (r2_match),
    .pending_mask (pending_mask),
    .empty        (tracker_empty)
  );

  assign run          = (state_q == ST_RUN);
  assign hazard       = instr_valid & ((r1_used & r1_match) | (r2_used & r2_match));
  assign hazard_stall = run & hazard & ~flush;
  assign issue        = run & instr_valid & ~hazard & ~flush & ~halt_in;
  assign bubble       = ~issue;
  assign stall        = hazard_stall | (state_q == ST_DRAIN) | (state_q == ST_HALTED);
  assign halted       = (state_q == ST_HALTED);
  assign stall_cycles = stall_cnt_q;

  // HALT never issues, so DRAIN only waits for older instructions to retire
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (instr_valid & halt_in & ~hazard & ~flush) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (tracker_empty) begin
            state_q <= ST_HALTED;
          end
        end
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_RUN;
      endcase
      if (hazard_stall && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and random checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       r1_used = 1'b0;
  logic       r2_used = 1'b0;
  logic [2:0] r1_sel = '0;
  logic [2:0] r2_sel = '0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_num = '0;
  logic       halt_in = 1'b0;
  logic       flush = 1'b0;
  logic       stall;
  logic       bubble;
  logic [7:0] pending_mask;
  logic       halted;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // model: in-flight slots (oldest last); dest = -1 when the slot writes nothing
  bit m_valid [3];
  int m_dest  [3];
  int m_mode;      // 0 running, 1 draining, 2 halted
  int m_cnt;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .r1_used      (r1_used),
    .r2_used      (r2_used),
    .r1_sel       (r1_sel),
    .r2_sel       (r2_sel),
    .wr_en        (wr_en),
    .wr_num       (wr_num),
    .halt_in      (halt_in),
    .flush        (flush),
    .stall        (stall),
    .bubble       (bubble),
    .pending_mask (pending_mask),
    .halted       (halted),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending(input int r);
    for (int i = 0; i < 3; i++) begin
      if (m_valid[i] && m_dest[i] == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0;
      m_dest[i]  = -1;
    end
    m_mode = 0;
    m_cnt  = 0;
  endtask

  // entered at posedge+1; returns at the next posedge+1
  task automatic cycle(input bit iv, input bit u1, input logic [2:0] s1, input bit u2,
                       input logic [2:0] s2, input bit we, input logic [2:0] wn,
                       input bit hi, input bit fl);
    bit run, haz, iss, all_empty;
    logic [7:0] exp_mask;
    instr_valid = iv; r1_used = u1; r1_sel = s1; r2_used = u2; r2_sel = s2;
    wr_en = we; wr_num = wn; halt_in = hi; flush = fl;
    #1;
    run = (m_mode == 0);
    haz = iv && ((u1 && pending(int'(s1))) || (u2 && pending(int'(s2))));
    iss = run && iv && !haz && !fl && !hi;
    exp_mask = '0;
    for (int i = 0; i < 3; i++) begin
      if (m_dest[i] >= 0) exp_mask[m_dest[i]] = 1'b1;
    end
    check("stall",        16'(stall),        16'(((run && haz && !fl) || !run) ? 1 : 0));
    check("bubble",       16'(bubble),       16'(iss ? 0 : 1));
    check("pending_mask", 16'(pending_mask), 16'(exp_mask));
    check("halted",       16'(halted),       16'(m_mode == 2 ? 1 : 0));
    check("stall_cycles", stall_cycles,      16'(m_cnt));
    @(posedge clk);
    #1;
    if (run && haz && !fl && m_cnt < 65535) m_cnt++;
    all_empty = !m_valid[0] && !m_valid[1] && !m_valid[2];
    if (run && iv && hi && !haz && !fl) m_mode = 1;
    else if (m_mode == 1 && all_empty) m_mode = 2;
    for (int i = 2; i > 0; i--) begin
      m_valid[i] = m_valid[i-1];
      m_dest[i]  = m_dest[i-1];
    end
    m_valid[0] = iss;
    m_dest[0]  = (iss && we) ? int'(wn) : -1;
  endtask

  // reset with arbitrary decode inputs, then confirm the cleared state
  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'($urandom); r1_used = 1'($urandom); r2_used = 1'($urandom);
    r1_sel = 3'($urandom); r2_sel = 3'($urandom); wr_en = 1'($urandom);
    wr_num = 3'($urandom); halt_in = 1'($urandom); flush = 1'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    instr_valid = 1'b0; halt_in = 1'b0; flush = 1'b0;
    model_clear();
    #1;
    check("rst_stall",  16'(stall),        16'h0000);
    check("rst_bubble", 16'(bubble),       16'h0001);
    check("rst_mask",   16'(pending_mask), 16'h0000);
    check("rst_halted", 16'(halted),       16'h0000);
    check("rst_count",  stall_cycles,      16'h0000);
  endtask

  initial begin
    int halted_run;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // back-to-back RAW on r3
    cycle(1, 0, 0, 0, 0, 1, 3, 0, 0);
    repeat (4) cycle(1, 1, 3, 0, 0, 0, 0, 0, 0);
    check("raw_count", stall_cycles, 16'd3);

    // write-disabled entry is never a hazard
    do_reset();
    cycle(1, 0, 0, 0, 0, 0, 3, 0, 0);
    check("nowr_mask", 16'(pending_mask), 16'h0000);
    cycle(1, 1, 3, 1, 3, 1, 3, 0, 0);
    check("self_mask", 16'(pending_mask), 16'h0008);

    // flush beats a pending hazard on r5
    do_reset();
    cycle(1, 0, 0, 0, 0, 1, 5, 0, 0);
    cycle(1, 1, 5, 0, 0, 0, 0, 0, 1);
    check("flush_count", stall_cycles, 16'h0000);

    // halt drain after a write to r2
    do_reset();
    cycle(1, 0, 0, 0, 0, 1, 2, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (10) cycle(1, 1, 2, 0, 0, 1, 1, 0, 0);
    check("halt_held", 16'(halted), 16'h0001);

    // randomized traffic
    do_reset();
    halted_run = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0 || halted_run > 6) begin
        do_reset();
        halted_run = 0;
      end
      cycle(($urandom_range(0, 4) != 0), 1'($urandom), 3'($urandom_range(0, 3)),
            1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0));
      if (m_mode == 2) halted_run++;
    end

    // counter saturation: each round is three stall cycles plus one issue
    do_reset();
    for (int n = 0; n < 87600; n++) begin
      cycle(1, 1, 4, 0, 0, 1, 4, 0, 0);
    end
    check("sat_count", stall_cycles, 16'hFFFF);

    // reset while draining
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("drain_stall", 16'(stall), 16'h0001);
    do_reset();
    cycle(1, 0, 0, 0, 0, 1, 6, 0, 0);
    check("post_rst_mask", 16'(pending_mask), 16'h0040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
